pc_ir_status_unit: RTL and testbench

- Consumer end of the LEGv8 control-word interface. Executes the PS, PCsel, IL and SL fields, and returns the instruction word I and the 5-bit status vector to the control unit.
- Owns PC, instruction register (IR), the address of the current instruction, and the latched V/C/N/Z flags.
- Fetches from instruction memory over a valid/req handshake, and raises stall to freeze the control unit state register while a fetch is outstanding.

---
 rtl/pc_ir_status_unit_pkg.sv | 22 ++
 rtl/pc_ir_status_unit_pc_next_logic.sv | 36 +++
 rtl/pc_ir_status_unit.sv | 89 ++++++++
 tb/tb_pc_ir_status_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ir_status_unit_pkg.sv
// Shared encodings for the PC / instruction register / status unit.
// Covers the PS field codes, the status vector bit positions and the fetch FSM states.
package pc_ir_status_unit_pkg;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;

  localparam int ST_V    = 4;
  localparam int ST_C    = 3;
  localparam int ST_N    = 2;
  localparam int ST_Z    = 1;
  localparam int ST_ZRAW = 0;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_ir_status_unit_pc_next_logic.sv
// Combinational next-PC selection: hold, increment, PC-relative branch or register jump.
// Also flags a misaligned target whenever a load is selected.
module pc_next_logic
  import pc_ir_status_unit_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ir_addr,
  input  logic [1:0]    ps,
  input  logic          pc_sel,
  input  logic [AW-1:0] constant,
  input  logic [AW-1:0] reg_a,
  output logic [AW-1:0] next_pc,
  output logic          misalign
);

  logic [AW-1:0] offset;
  logic [AW-1:0] target;

  // Branch offsets count instructions, so scale to bytes before adding.
  assign offset = constant << 2;
  assign target = pc_sel ? (ir_addr + offset) : reg_a;

  always_comb begin
    next_pc = pc;
    case (ps)
      PS_HOLD: next_pc = pc;
      PS_INC:  next_pc = pc + AW'(4);
      default: next_pc = target;
    endcase
  end

  assign misalign = ps[1] && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_ir_status_unit.sv
// Executes the PS/PCsel/IL/SL control-word fields: owns PC, IR, the current
// instruction address and latched flags, and stalls the control unit during fetches.
module pc_ir_status_unit
  import pc_ir_status_unit_pkg::*;
#(
  parameter int          AW       = 64,
  parameter logic [AW-1:0] RESET_PC = DEFAULT_RESET_PC[AW-1:0]
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    PS,
  input  logic          PCsel,
  input  logic          IL,
  input  logic          SL,
  input  logic [63:0]   constant,
  input  logic [63:0]   reg_a,
  input  logic [3:0]    alu_flags,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  output logic [31:0]   I,
  output logic [AW-1:0] pc,
  output logic [4:0]    status,
  output logic          stall,
  output logic          align_fault
);

  fetch_state_t  state;
  logic [AW-1:0] ir_addr;
  logic [3:0]    flags;
  logic [AW-1:0] next_pc;
  logic          misalign;
  logic          fetching;
  logic          fetch_done;

  pc_next_logic #(.AW(AW)) u_pc_next (
    .pc       (pc),
    .ir_addr  (ir_addr),
    .ps       (PS),
    .pc_sel   (PCsel),
    .constant (constant[AW-1:0]),
    .reg_a    (reg_a[AW-1:0]),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  // A fetch is in flight either when newly requested in IDLE or while parked in WAIT.
  assign fetching   = (state == WAIT) || IL;
  assign fetch_done = fetching && imem_valid;
  assign imem_req   = fetching;
  assign imem_addr  = pc;
  assign stall      = fetching && !imem_valid;

  assign status[ST_V:ST_Z] = flags;
  assign status[ST_ZRAW]   = alu_flags[0];

  // While stalled the whole control word is frozen, so PC, flags and IR all hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir_addr     <= RESET_PC;
      I           <= 32'h0;
      flags       <= 4'h0;
      align_fault <= 1'b0;
    end else begin
      if (!stall) begin
        pc <= next_pc;
        if (misalign) begin
          align_fault <= 1'b1;
        end
        if (SL) begin
          flags <= alu_flags;
        end
      end
      if (fetch_done) begin
        I       <= imem_rdata;
        ir_addr <= pc;
      end
      case (state)
        IDLE:    state <= stall ? WAIT : IDLE;
        WAIT:    state <= imem_valid ? IDLE : WAIT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ir_status_unit.sv
// Directed scoreboard bench for pc_ir_status_unit: expected values are queued
// as each step is driven and compared against the DUT after settling.
module tb_pc_ir_status_unit;
  import pc_ir_status_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  PS;
  logic        PCsel;
  logic        IL;
  logic        SL;
  logic [63:0] constant;
  logic [63:0] reg_a;
  logic [3:0]  alu_flags;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] I;
  logic [63:0] pc;
  logic [4:0]  status;
  logic        stall;
  logic        align_fault;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } exp_t;

  exp_t expQ[$];

  pc_ir_status_unit #(.AW(64), .RESET_PC(64'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .PS          (PS),
    .PCsel       (PCsel),
    .IL          (IL),
    .SL          (SL),
    .constant    (constant),
    .reg_a       (reg_a),
    .alu_flags   (alu_flags),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .I           (I),
    .pc          (pc),
    .status      (status),
    .stall       (stall),
    .align_fault (align_fault)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [1:0] ps, input logic pcsel, input logic il,
                               input logic sl, input logic [63:0] cnst, input logic [63:0] ra,
                               input logic [3:0] fl, input logic [31:0] rd, input logic vld);
    PS         = ps;
    PCsel      = pcsel;
    IL         = il;
    SL         = sl;
    constant   = cnst;
    reg_a      = ra;
    alu_flags  = fl;
    imem_rdata = rd;
    imem_valid = vld;
  endtask

  task automatic expectVal(input string tag, input logic [63:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  function automatic logic [63:0] observe(input string tag);
    case (tag)
      "pc":     return pc;
      "I":      return {32'h0, I};
      "stall":  return {63'h0, stall};
      "req":    return {63'h0, imem_req};
      "addr":   return imem_addr;
      "status": return {59'h0, status};
      "fault":  return {63'h0, align_fault};
      default:  return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic [63:0] got;
    while (expQ.size() > 0) begin
      e   = expQ.pop_front();
      got = observe(e.tag);
      assertCount++;
      assert (got === e.value) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, got, e.value);
      end
    end
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    expectVal("pc", 64'h0);
    expectVal("I", 64'h0);
    expectVal("status", 64'h0);
    expectVal("fault", 64'h0);
    expectVal("stall", 64'h0);
    expectVal("req", 64'h0);
    checkOutput();
    reset = 1'b0;

    // zero-wait fetch
    applyStimulus(PS_INC, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 32'h8B020020, 1'b1);
    expectVal("req", 64'h1);
    expectVal("addr", 64'h0);
    expectVal("stall", 64'h0);
    settle();
    expectVal("I", 64'h8B020020);
    expectVal("pc", 64'h4);
    tick();

    applyStimulus(PS_INC, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 32'h1111_1111, 1'b1);
    expectVal("addr", 64'h4);
    expectVal("stall", 64'h0);
    settle();
    expectVal("I", 64'h1111_1111);
    expectVal("pc", 64'h8);
    tick();

    // three wait cycles; PS and SL must be ignored while stalled
    for (int i = 0; i < 3; i++) begin
      applyStimulus(PS_INC, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 4'b1110, 32'hFFFF_0000, 1'b0);
      expectVal("stall", 64'h1);
      expectVal("req", 64'h1);
      expectVal("addr", 64'h8);
      settle();
      expectVal("pc", 64'h8);
      expectVal("I", 64'h1111_1111);
      expectVal("status", 64'h0);
      tick();
    end
    applyStimulus(PS_INC, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 32'hAAAA_5555, 1'b1);
    expectVal("stall", 64'h0);
    expectVal("addr", 64'h8);
    settle();
    expectVal("I", 64'hAAAA_5555);
    expectVal("pc", 64'hC);
    expectVal("status", 64'h0);
    tick();

    // jump to 0x100 then fetch there so IR_addr = 0x100
    applyStimulus(PS_LOAD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100, 4'h0, 32'h0, 1'b0);
    expectVal("req", 64'h0);
    expectVal("stall", 64'h0);
    settle();
    expectVal("pc", 64'h100);
    expectVal("fault", 64'h0);
    tick();

    applyStimulus(PS_HOLD, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 32'h1234_5678, 1'b1);
    settle();
    expectVal("I", 64'h1234_5678);
    expectVal("pc", 64'h100);
    tick();

    // PC-relative branch backwards by two instructions
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3333, 4'h0, 32'h0, 1'b0);
    settle();
    expectVal("pc", 64'hF8);
    expectVal("fault", 64'h0);
    tick();

    // misaligned register jump: loaded as-is, fault is sticky
    applyStimulus(PS_LOAD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h2002, 4'h0, 32'h0, 1'b0);
    settle();
    expectVal("pc", 64'h2002);
    expectVal("fault", 64'h1);
    tick();

    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'h0, 1'b0);
    settle();
    expectVal("pc", 64'h2002);
    expectVal("fault", 64'h1);
    tick();

    // status load and raw Z passthrough
    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 4'b1011, 32'h0, 1'b0);
    expectVal("status", 64'h1);
    settle();
    expectVal("status", 64'h17);
    tick();

    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0000, 32'h0, 1'b0);
    expectVal("status", 64'h16);
    settle();
    expectVal("status", 64'h16);
    tick();

    // PC wrap at the top of the address space
    applyStimulus(PS_LOAD, 1'b0, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'h0, 32'h0, 1'b0);
    settle();
    expectVal("pc", 64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    applyStimulus(PS_INC, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'h0, 1'b0);
    settle();
    expectVal("pc", 64'h0);
    expectVal("fault", 64'h1);
    tick();

    // reset while parked in WAIT, then a late valid must be ignored
    applyStimulus(PS_INC, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 32'h0, 1'b0);
    expectVal("stall", 64'h1);
    settle();
    expectVal("stall", 64'h1);
    expectVal("req", 64'h1);
    tick();

    reset = 1'b1;
    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    settle();
    expectVal("pc", 64'h0);
    expectVal("I", 64'h0);
    expectVal("fault", 64'h0);
    expectVal("status", 64'h0);
    tick();
    reset = 1'b0;

    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
    expectVal("req", 64'h0);
    expectVal("stall", 64'h0);
    settle();
    expectVal("I", 64'h0);
    expectVal("pc", 64'h0);
    tick();

    applyStimulus(PS_HOLD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 32'h0, 1'b0);
    expectVal("req", 64'h0);
    expectVal("stall", 64'h0);
    settle();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
